acs_butterfly: RTL and testbench

Radix-2 add-compare-select butterfly for the hard-decision rate-1/2, 64-state Viterbi decoder. It consumes the `path_0_bmc` / `path_1_bmc` branch metrics produced by one branch-metric (bmc) cell and the path metrics of predecessor states j and j+32. It produces registered path metrics and survivor decision bits for successor states 2j and 2j+1. Thirty-two instances form one trellis stage; their decision bits feed the traceback memory.

---
 rtl/acs_butterfly.sv | 97 +++++++++
 tb/tb_acs_butterfly.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/acs_butterfly.sv
// acs_butterfly
//   Radix-2 add-compare-select butterfly for a 64-state, rate-1/2
//   hard-decision Viterbi decoder. It takes the predecessor metrics of
//   states j (pm_a) and j+32 (pm_b) and produces registered metrics and
//   survivor decisions for successor states 2j (even) and 2j+1 (odd).
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   in_valid            symbol inputs valid; all registers load only then
//   sof                 first symbol of a frame (INIT_A/INIT_B replace pm_a/pm_b)
//   path_0_bmc          branch metric of the branch-label path (0..2)
//   path_1_bmc          branch metric of the complementary-label path (0..2)
//   pm_a, pm_b          predecessor path metrics (states j, j+32)
//   norm_en             subtract 2^(PM_W-1) from both results, floored at 0
//   pm_even, pm_odd     registered successor metrics
//   dec_even, dec_odd   survivor decisions (1 = came from j+32)
//   out_valid           one-cycle strobe per accepted symbol
//   above_half          both metrics have the MSB set (feeds the global norm AND)
module acs_butterfly #(
  parameter int PM_W   = 8,
  parameter int INIT_A = 0,
  parameter int INIT_B = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            sof,
  input  logic [1:0]      path_0_bmc,
  input  logic [1:0]      path_1_bmc,
  input  logic [PM_W-1:0] pm_a,
  input  logic [PM_W-1:0] pm_b,
  input  logic            norm_en,
  output logic [PM_W-1:0] pm_even,
  output logic [PM_W-1:0] pm_odd,
  output logic            dec_even,
  output logic            dec_odd,
  output logic            out_valid,
  output logic            above_half
);

  localparam logic [PM_W-1:0] HALF = {1'b1, {(PM_W-1){1'b0}}};

  // Add at PM_W+1 bits; any carry out clamps to the all-ones maximum.
  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] m,
                                               input logic [1:0]      bm);
    logic [PM_W:0] s;
    s = {1'b0, m} + {{(PM_W-1){1'b0}}, bm};
    return s[PM_W] ? {PM_W{1'b1}} : s[PM_W-1:0];
  endfunction

  function automatic logic [PM_W-1:0] norm(input logic [PM_W-1:0] m,
                                           input logic            en);
    if (!en)       return m;
    if (m >= HALF) return m - HALF;
    return '0;
  endfunction

  logic [PM_W-1:0] a, b;
  logic [PM_W-1:0] ea, eb, oa, ob;
  logic            sel_e, sel_o;
  logic [PM_W-1:0] nxt_e, nxt_o;

  always_comb begin
    a  = sof ? PM_W'(INIT_A) : pm_a;
    b  = sof ? PM_W'(INIT_B) : pm_b;
    ea = sat_add(a, path_0_bmc);
    eb = sat_add(b, path_1_bmc);
    oa = sat_add(a, path_1_bmc);
    ob = sat_add(b, path_0_bmc);
    // Strict compare: ties resolve to the j (a) predecessor.
    sel_e = (eb < ea);
    sel_o = (ob < oa);
    nxt_e = norm(sel_e ? eb : ea, norm_en);
    nxt_o = norm(sel_o ? ob : oa, norm_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pm_even   <= '0;
      pm_odd    <= '0;
      dec_even  <= 1'b0;
      dec_odd   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        pm_even  <= nxt_e;
        pm_odd   <= nxt_o;
        dec_even <= sel_e;
        dec_odd  <= sel_o;
      end
    end
  end

  assign above_half = pm_even[PM_W-1] & pm_odd[PM_W-1];

endmodule

// File: tb/tb_acs_butterfly.sv
module tb_acs_butterfly;

  logic       clk = 1'b0;
  logic       rst, in_valid, sof, norm_en;
  logic [1:0] path_0_bmc, path_1_bmc;
  logic [7:0] pm_a, pm_b;
  logic [7:0] pm_even, pm_odd;
  logic       dec_even, dec_odd, out_valid, above_half;

  acs_butterfly #(.PM_W(8), .INIT_A(0), .INIT_B(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sof(sof),
    .path_0_bmc(path_0_bmc), .path_1_bmc(path_1_bmc),
    .pm_a(pm_a), .pm_b(pm_b), .norm_en(norm_en),
    .pm_even(pm_even), .pm_odd(pm_odd), .dec_even(dec_even), .dec_odd(dec_odd),
    .out_valid(out_valid), .above_half(above_half)
  );

  always #5 clk = ~clk;

  // {pm_even, pm_odd, dec_even, dec_odd, above_half, out_valid}
  typedef struct packed {
    logic [7:0] pe;
    logic [7:0] po;
    logic       de;
    logic       dod;
    logic       ah;
    logic       ov;
  } obs_t;

  obs_t sb[$];
  obs_t last;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic obs_t observe();
    return {pm_even, pm_odd, dec_even, dec_odd, above_half, out_valid};
  endfunction

  function automatic obs_t mk(int pe, int po, int de, int dod, int ah, int ov);
    obs_t r;
    r.pe = 8'(pe); r.po = 8'(po); r.de = de[0]; r.dod = dod[0];
    r.ah = ah[0];  r.ov = ov[0];
    return r;
  endfunction

  // Reference model in plain integers.
  function automatic obs_t model(int pa, int pb, int b0, int b1, int sf, int nm);
    int a, b, ea, eb, oa, ob, pe, po, de, dod;
    a  = sf ? 0  : pa;
    b  = sf ? 64 : pb;
    ea = (a + b0 > 255) ? 255 : a + b0;
    eb = (b + b1 > 255) ? 255 : b + b1;
    oa = (a + b1 > 255) ? 255 : a + b1;
    ob = (b + b0 > 255) ? 255 : b + b0;
    de  = (eb < ea) ? 1 : 0;
    dod = (ob < oa) ? 1 : 0;
    pe  = de  ? eb : ea;
    po  = dod ? ob : oa;
    if (nm) begin
      pe = (pe >= 128) ? pe - 128 : 0;
      po = (po >= 128) ? po - 128 : 0;
    end
    return mk(pe, po, de, dod, (pe >= 128 && po >= 128) ? 1 : 0, 1);
  endfunction

  task automatic drive(input logic v, input logic sf, input logic nm,
                       input logic [1:0] b0, input logic [1:0] b1,
                       input logic [7:0] pa, input logic [7:0] pb);
    @(negedge clk);
    in_valid = v; sof = sf; norm_en = nm;
    path_0_bmc = b0; path_1_bmc = b1; pm_a = pa; pm_b = pb;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t g;
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 2'd2, 2'd1, 8'd200, 8'd201);
    g = observe(); n_checks++;
    if (g !== obs_t'(0)) begin
      n_fail++; $display("FAIL reset: got %h want %h", g, obs_t'(0));
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b1, 2'd1, 2'd2, 8'($urandom), 8'($urandom));
      g = observe(); n_checks++;
      if (g !== obs_t'(0)) begin
        n_fail++; $display("FAIL reset_idle[%0d]: got %h want %h", i, g, obs_t'(0));
      end
    end
    last = '0;
  endtask

  // Directed scenarios: expected values are literal numbers worked by hand.
  task automatic test_directed();
    obs_t g, e;
    sb.push_back(mk(10, 12, 0, 0, 0, 1));
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 8'd10, 8'd20);
    e = sb.pop_front(); g = observe(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL basic_select: got %h want %h", g, e); end

    sb.push_back(mk(6, 5, 0, 1, 0, 1));
    drive(1'b1, 1'b0, 1'b0, 2'd1, 2'd2, 8'd5, 8'd4);
    e = sb.pop_front(); g = observe(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL tie_bwins: got %h want %h", g, e); end

    sb.push_back(mk(255, 255, 0, 0, 1, 1));
    drive(1'b1, 1'b0, 1'b0, 2'd2, 2'd2, 8'd254, 8'd255);
    e = sb.pop_front(); g = observe(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL saturation: got %h want %h", g, e); end

    sb.push_back(mk(22, 23, 1, 1, 0, 1));
    drive(1'b1, 1'b0, 1'b1, 2'd1, 2'd0, 8'd200, 8'd150);
    e = sb.pop_front(); g = observe(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL normalize: got %h want %h", g, e); end

    sb.push_back(mk(0, 0, 0, 0, 0, 1));
    drive(1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 8'd10, 8'd20);
    e = sb.pop_front(); g = observe(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL normalize_floor: got %h want %h", g, e); end

    // sof with norm_en: init 0/64 first, then floor -> 0, 0
    sb.push_back(mk(0, 0, 0, 0, 0, 1));
    drive(1'b1, 1'b1, 1'b1, 2'd2, 2'd2, 8'd250, 8'd250);
    e = sb.pop_front(); g = observe(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL sof_norm: got %h want %h", g, e); end
  endtask

  task automatic test_sof_hold();
    obs_t g, e;
    // Load something non-zero first so the sof result is distinguishable.
    sb.push_back(mk(255, 255, 0, 0, 1, 1));
    drive(1'b1, 1'b0, 1'b0, 2'd2, 2'd2, 8'd254, 8'd255);
    e = sb.pop_front(); g = observe(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL pre_sof: got %h want %h", g, e); end

    sb.push_back(mk(0, 0, 0, 0, 0, 1));
    drive(1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 8'd99, 8'd99);
    e = sb.pop_front(); g = observe(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL sof: got %h want %h", g, e); end

    e.ov = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, i[0], ~i[0], 2'(i), 2'(2 - i), 8'(200 + i), 8'(i));
      g = observe(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL hold[%0d]: got %h want %h", i, g, e); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t g, e;
    int pa, pb, b0, b1, sf, nm;
    for (int i = 0; i < 40; i++) begin
      pa = $urandom_range(255); pb = $urandom_range(255);
      b0 = $urandom_range(2);   b1 = $urandom_range(2);
      sf = ($urandom_range(7) == 0) ? 1 : 0;
      nm = ($urandom_range(3) == 0) ? 1 : 0;
      if (i % 8 == 0) begin pa = 250 + (i % 6); pb = 252; end
      sb.push_back(model(pa, pb, b0, b1, sf, nm));
      drive(1'b1, sf[0], nm[0], 2'(b0), 2'(b1), 8'(pa), 8'(pb));
      if (sb.size() == 0) begin
        n_checks++; n_fail++; $display("FAIL b2b[%0d]: scoreboard empty", i);
      end else begin
        e = sb.pop_front(); g = observe(); n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL b2b[%0d]: got %h want %h", i, g, e); end
      end
    end
    // Reset mid-frame beats a simultaneous valid symbol.
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 8'd180, 8'd190);
    rst = 1'b0;
    g = observe(); n_checks++;
    if (g !== obs_t'(0)) begin
      n_fail++; $display("FAIL reset_midframe: got %h want %h", g, obs_t'(0));
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; sof = 1'b0; norm_en = 1'b0;
    path_0_bmc = '0; path_1_bmc = '0; pm_a = '0; pm_b = '0;
    test_reset();
    test_directed();
    test_sof_hold();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
